// File: rtl/mux_share_arbiter_pkg.sv
// Shared encodings and the tie-break helper for the mux-sharing arbiter.
package mux_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Winner among active requesters; on a tie the one that did not own last wins.
  function automatic logic arb_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    else if (req[REQ1]) return REQ1;
    else return REQ0;
  endfunction

endpackage

// File: rtl/mux_share_arbiter_mux2_w.sv
// Combinational DATA_W-wide 2:1 mux: y = s ? i1 : i0.
module mux2_w #(
  parameter int DATA_W = 1
) (
  input  logic              s,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  output logic [DATA_W-1:0] y
);

  assign y = s ? i1 : i0;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux with bounded tenure, a one-cycle
// dead gap on every handover, and a registered mux output with valid.
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int TW = $clog2(MAX_HOLD + 1);
  localparam logic [TW-1:0] HOLD_MAX = TW'(MAX_HOLD);

  state_t            state;
  logic              owner;
  logic              last;
  logic [TW-1:0]     tenure;
  logic              pick;
  logic              release_now;
  logic [DATA_W-1:0] mux_y;

  mux2_w #(.DATA_W(DATA_W)) u_mux (
    .s  (sel),
    .i0 (din0),
    .i1 (din1),
    .y  (mux_y)
  );

  assign pick = arb_pick(req, last);
  // Owner gives up the mux when it drops req or is preempted at full tenure.
  assign release_now = !req[owner] || ((tenure == HOLD_MAX) && req[~owner]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= REQ0;
      last       <= REQ1;
      tenure     <= '0;
      gnt        <= 2'b00;
      sel        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          if (|req) begin
            state  <= ST_OWN;
            owner  <= pick;
            sel    <= pick;
            gnt    <= {pick, ~pick};
            tenure <= TW'(1);
            busy   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
          end
        end
        ST_OWN: begin
          if (req[owner]) begin
            dout       <= mux_y;
            dout_valid <= 1'b1;
          end
          if (release_now) begin
            state  <= ST_GAP;
            last   <= owner;
            gnt    <= 2'b00;
            tenure <= '0;
            busy   <= 1'b1;
          end else if (tenure != HOLD_MAX) begin
            tenure <= tenure + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the arbiter.
module tb_mux_share_arbiter;

  localparam int DW = 1;
  localparam int MAXH = 4;

  typedef struct packed {
    logic [1:0]    gnt;
    logic          sel;
    logic [DW-1:0] dout;
    logic          dv;
    logic          busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [DW-1:0] din0, din1;
  logic [1:0]    gnt;
  logic          sel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t q[$];

  // Reference model state: owner -1 means nobody holds or waits on the mux.
  int            m_owner;
  bit            m_gap;
  int            m_held;
  int            m_last;
  logic          m_sel;
  logic [DW-1:0] m_dout;
  logic          m_dv;

  mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    exp_t e;
    bit   owning;
    int   w;
    if (!rst_n) begin
      m_owner = -1; m_gap = 0; m_held = 0; m_last = 1;
      m_sel = 1'b0; m_dout = '0; m_dv = 1'b0;
      q.delete();
    end else begin
      owning = (m_owner >= 0) && !m_gap;
      m_dv = 1'b0;
      if (owning && req[m_owner]) begin
        m_dout = (m_owner == 1) ? din1 : din0;
        m_dv = 1'b1;
      end
      if (owning) begin
        if (!req[m_owner] || (m_held >= MAXH && req[1 - m_owner])) begin
          m_last = m_owner;
          m_gap = 1;
        end else if (m_held < MAXH) begin
          m_held++;
        end
      end else begin
        w = -1;
        if (req == 2'b11) w = 1 - m_last;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        m_gap = 0;
        if (w >= 0) begin
          m_owner = w; m_held = 1; m_sel = (w == 1);
        end else begin
          m_owner = -1;
        end
      end
    end
    e.gnt  = ((m_owner >= 0) && !m_gap) ? (2'b01 << m_owner) : 2'b00;
    e.sel  = m_sel;
    e.dout = m_dout;
    e.dv   = m_dv;
    e.busy = (m_owner >= 0);
    q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic check_cycle();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    cyc++;
    tests++;
    if (gnt !== e.gnt || sel !== e.sel || dout !== e.dout ||
        dout_valid !== e.dv || busy !== e.busy) begin
      fails++;
      $display("FAIL outputs cyc=%0d: got gnt=%b sel=%b dout=%h dv=%b busy=%b, expected gnt=%b sel=%b dout=%h dv=%b busy=%b",
               cyc, gnt, sel, dout, dout_valid, busy, e.gnt, e.sel, e.dout, e.dv, e.busy);
    end else if (e.dv) begin
      $display("[TB] cyc=%0d sample gnt=%b sel=%b dout=%h ok", cyc, gnt, sel, dout);
    end
  endtask

  always @(negedge clk) check_cycle();

  task automatic step(input logic [1:0] r, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    req = r; din0 = d0; din1 = d1;
  endtask

  initial begin
    logic [1:0] r;
    rst_n = 1'b0;
    req = 2'b11; din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie at reset release, then req1 waits behind req0 for the full tenure.
    for (int i = 0; i < 12; i++) step(2'b11, DW'($urandom), DW'($urandom));
    // req0 alone: never preempted.
    for (int i = 0; i < 12; i++) step(2'b01, DW'($urandom), DW'($urandom));
    // req1 takes over, drops after 2 cycles while req0 pending, then both alternate.
    step(2'b10, '0, '1);
    step(2'b10, '0, '1);
    step(2'b10, '0, '1);
    step(2'b11, '1, '0);
    step(2'b01, '1, '0);
    for (int i = 0; i < 24; i++) step(2'b11, DW'($urandom), DW'($urandom));

    // Random sticky requests.
    r = 2'b00;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 5) == 0) r[1] = ~r[1];
      step(r, DW'($urandom), DW'($urandom));
    end

    // Asynchronous reset in the middle of a grant.
    for (int i = 0; i < 4; i++) step(2'b01, DW'($urandom), DW'($urandom));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (gnt !== 2'b00 || sel !== 1'b0 || dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got gnt=%b sel=%b dout=%h dv=%b busy=%b, expected all zero",
               gnt, sel, dout, dout_valid, busy);
    end
    req = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(2'b11, DW'($urandom), DW'($urandom));

    // Requester 1 owns while din1 toggles and din0 stays high.
    for (int i = 0; i < 6; i++) step(2'b10, '1, '0);
    for (int i = 0; i < 10; i++) step(2'b10, '1, DW'(i & 1));
    step(2'b00, '0, '0);
    step(2'b00, '0, '0);

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
